// File: rtl/bluejay_cmd_ctrl_pkg.sv
// bluejay_cmd_ctrl_pkg: opcodes, response bytes, gap timeout and sequencer state encoding
package bluejay_cmd_ctrl_pkg;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
  localparam logic [7:0] RD_HDR = 8'h72;
  localparam int GAP_CYCLES = 17360;
  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_DATA, SPI_ARM, SPI_WAIT,
    TX_HDR, TX_HDR_WAIT, TX_DAT, TX_DAT_WAIT
  } state_t;
  function automatic logic accepting(state_t s);
    return s inside {IDLE, GET_ADDR, GET_DATA};
  endfunction
endpackage

// File: rtl/bluejay_cmd_ctrl_byte_gap_timer.sv
// byte_gap_timer: inter-byte gap counter with clear and one-cycle expire pulse
// (only instantiated when BLUEJAY_CMD_GAP_TIMEOUT_EN is defined)
module byte_gap_timer #(
  parameter int CYCLES = 17360
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic expire
);
  localparam int W = $clog2(CYCLES);
  logic [W-1:0] cnt;
  assign expire = run && !clr && cnt == W'(CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || !run || expire) ? '0 : cnt + W'(1);
endmodule

// File: rtl/bluejay_cmd_ctrl.sv
// bluejay_cmd_ctrl: UART 3-byte command frames -> one 16-bit SPI transaction -> UART response
// BLUEJAY_CMD_GAP_TIMEOUT_EN defined: partial frames are abandoned with NAK after an inter-byte gap.
module bluejay_cmd_ctrl
  import bluejay_cmd_ctrl_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_active,
  input  logic       i_tx_done,
  output logic       o_spi_start,
  output logic [7:0] o_spi_upper,
  output logic [7:0] o_spi_lower,
  input  logic       i_spi_busy,
  input  logic       i_spi_complete,
  input  logic [7:0] i_spi_rx,
  output logic       o_busy,
  output logic [7:0] o_drop_cnt
);
  state_t state, nxt;
  logic [7:0] op, addr, data, rx_data, hdr;
  logic expire;
`ifdef BLUEJAY_CMD_GAP_TIMEOUT_EN
  byte_gap_timer #(.CYCLES(GAP_CYCLES)) u_gap (
    .clk(i_clock),
    .rst(i_reset),
    .run(state == GET_ADDR || state == GET_DATA),
    .clr(i_rx_dv),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:        if (i_rx_dv) nxt = (i_rx_byte == OP_WRITE || i_rx_byte == OP_READ) ? GET_ADDR : TX_HDR;
      GET_ADDR:    nxt = i_rx_dv ? GET_DATA : expire ? TX_HDR : GET_ADDR;
      GET_DATA:    nxt = i_rx_dv ? SPI_ARM : expire ? TX_HDR : GET_DATA;
      SPI_ARM:     if (!i_spi_busy) nxt = SPI_WAIT;
      SPI_WAIT:    if (i_spi_complete) nxt = TX_HDR;
      TX_HDR:      if (!i_tx_active) nxt = TX_HDR_WAIT;
      TX_HDR_WAIT: if (i_tx_done) nxt = (hdr == RD_HDR) ? TX_DAT : IDLE;
      TX_DAT:      if (!i_tx_active) nxt = TX_DAT_WAIT;
      TX_DAT_WAIT: if (i_tx_done) nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end
  // hdr defaults to NAK at the opcode and only becomes ACK/'r' after a completed SPI transfer
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      o_tx_dv <= 1'b0;
      o_tx_byte <= '0;
      o_spi_start <= 1'b0;
      o_spi_upper <= '0;
      o_spi_lower <= '0;
      o_drop_cnt <= '0;
      op <= '0;
      addr <= '0;
      data <= '0;
      rx_data <= '0;
      hdr <= '0;
    end else begin
      o_spi_start <= state == SPI_ARM && !i_spi_busy;
      o_tx_dv <= (state == TX_HDR || state == TX_DAT) && !i_tx_active;
      if (state == IDLE && i_rx_dv) begin
        op <= i_rx_byte;
        hdr <= NAK_BYTE;
      end
      if (state == GET_ADDR && i_rx_dv) addr <= i_rx_byte;
      if (state == GET_DATA && i_rx_dv) data <= i_rx_byte;
      if (state == SPI_ARM && !i_spi_busy) begin
        o_spi_upper <= addr;
        o_spi_lower <= (op == OP_READ) ? 8'h00 : data;
      end
      if (state == SPI_WAIT && i_spi_complete) begin
        rx_data <= i_spi_rx;
        hdr <= (op == OP_READ) ? RD_HDR : ACK_BYTE;
      end
      if (state == TX_HDR && !i_tx_active) o_tx_byte <= hdr;
      if (state == TX_DAT && !i_tx_active) o_tx_byte <= rx_data;
      if (!accepting(state) && i_rx_dv && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
    end
endmodule

// File: tb/tb_bluejay_cmd_ctrl.sv
// tb_bluejay_cmd_ctrl: randomized frames against a transaction-level model of the command sequencer
module tb_bluejay_cmd_ctrl;
  logic clk = 0;
  logic rst = 1;
  logic rx_dv = 0;
  logic [7:0] rx_byte = 0;
  logic tx_dv;
  logic [7:0] tx_byte;
  logic tx_active = 0;
  logic tx_done = 0;
  logic spi_start;
  logic [7:0] spi_upper, spi_lower;
  logic spi_busy = 0;
  logic spi_complete = 0;
  logic [7:0] spi_rx = 0;
  logic busy;
  logic [7:0] drop_cnt;

  bluejay_cmd_ctrl dut (
    .i_clock(clk), .i_reset(rst), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
    .o_tx_dv(tx_dv), .o_tx_byte(tx_byte), .i_tx_active(tx_active), .i_tx_done(tx_done),
    .o_spi_start(spi_start), .o_spi_upper(spi_upper), .o_spi_lower(spi_lower),
    .i_spi_busy(spi_busy), .i_spi_complete(spi_complete), .i_spi_rx(spi_rx),
    .o_busy(busy), .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_tx[$];
  logic [15:0] exp_spi[$];
  logic [7:0] tx_log[$];
  logic [15:0] last_spi = 0;
  logic [15:0] e_spi;
  int exp_drop = 0;
  bit uart_busy = 0;
  int ua_n, ua_x;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // every strobe must match the next expected SPI word / tx byte of the model
  always @(negedge clk) if (!rst) begin
    if (spi_start) begin
      last_spi = {spi_upper, spi_lower};
      if (exp_spi.size() == 0) check("unexpected_spi_start", 1, 0);
      else begin
        e_spi = exp_spi.pop_front();
        check("spi_word", {spi_upper, spi_lower}, e_spi);
      end
    end
    if (tx_dv) begin
      tx_log.push_back(tx_byte);
      if (exp_tx.size() == 0) check("unexpected_tx_dv", 1, 0);
      else check("tx_byte", tx_byte, exp_tx.pop_front());
    end
  end

  // UART transmitter stand-in: random busy time, sometimes stays active past done
  always begin
    @(negedge clk);
    if (tx_dv && !rst) begin
      ua_n = $urandom_range(2, 10);
      ua_x = $urandom_range(0, 3);
      uart_busy = 1;
      @(posedge clk);
      #1 tx_active = 1;
      repeat (ua_n) @(posedge clk);
      #1 tx_done = 1;
      tx_active = (ua_x != 0);
      @(posedge clk);
      #1 tx_done = 0;
      repeat (ua_x) @(posedge clk);
      #1 tx_active = 0;
      uart_busy = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    rx_dv = 1;
    rx_byte = b;
    tick();
    rx_dv = 0;
  endtask

  task automatic wait_uart();
    int g = 0;
    while (uart_busy && g < 100) begin
      tick();
      g++;
    end
    check("uart_settle", uart_busy, 0);
  endtask

  task automatic wait_idle(input int lim);
    int g = 0;
    @(negedge clk);
    while (busy && g < lim) begin
      @(negedge clk);
      g++;
    end
    check("idle_reached", busy, 0);
    check("tx_pending", exp_tx.size(), 0);
    check("spi_pending", exp_spi.size(), 0);
    check("drop_cnt", drop_cnt, exp_drop);
    tick();
  endtask

  task automatic wait_spi_start();
    int g = 0;
    @(negedge clk);
    while (!spi_start && g < 30) begin
      @(negedge clk);
      g++;
    end
    check("spi_start_seen", spi_start, 1);
    tick();
  endtask

  task automatic do_reset();
    rst = 1;
    exp_tx.delete();
    exp_spi.delete();
    exp_drop = 0;
    @(negedge clk);
    check("reset_outputs", {spi_start, spi_upper, spi_lower, tx_dv, tx_byte, busy}, 0);
    check("reset_drop", drop_cnt, 0);
    tick();
    rst = 0;
    tick();
  endtask

  // last frame byte onward: SPI arm/busy, drops in SPI_WAIT, completion and response latency
  task automatic spi_phase(input logic [7:0] last, input logic [15:0] word, input logic [7:0] srx,
                           input int blen, input int ndrop, input bit coin);
    int found = -1;
    int k = 0;
    int expc = ((blen > 1) ? blen : 1) + 1;
    spi_busy = (blen > 0);
    rx_dv = 1;
    rx_byte = last;
    while (found < 0 && k < blen + 10) begin
      @(negedge clk);
      if (spi_start) found = k;
      tick();
      rx_dv = 0;
      k++;
      spi_busy = (k < blen);
    end
    check("start_latency", found, expc);
    spi_busy = 1;
    for (int i = 0; i < ndrop; i++) begin
      send(8'($urandom));
      tick();
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end
    tick();
    @(negedge clk);
    check("spi_hold", {spi_upper, spi_lower}, word);
    tick();
    spi_complete = 1;
    spi_rx = srx;
    spi_busy = 0;
    if (coin) begin
      rx_dv = 1;
      rx_byte = 8'($urandom);
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end
    tick();
    spi_complete = 0;
    rx_dv = 0;
    spi_rx = 8'($urandom);
    @(negedge clk);
    check("tx_early", tx_dv, 0);
    tick();
    @(negedge clk);
    check("tx_latency", tx_dv, 1);
    tick();
    wait_idle(2000);
  endtask

  task automatic run(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] srx, input int blen, input int ndrop, input bit coin);
    bit w, r;
    w = (op == 8'h57);
    r = (op == 8'h52);
    wait_uart();
    if (w || r) begin
      exp_spi.push_back({a, r ? 8'h00 : d});
      exp_tx.push_back(r ? 8'h72 : 8'h06);
      if (r) exp_tx.push_back(srx);
    end else exp_tx.push_back(8'h15);
    send(op);
    if (w || r) begin
      send(a);
      spi_phase(d, {a, r ? 8'h00 : d}, srx, blen, ndrop, coin);
    end else wait_idle(2000);
  endtask

  initial begin
    int n0;
    logic [7:0] b;
    tick();
    do_reset();
    run(8'h57, 8'hF8, 8'hA5, 8'h11, 0, 0, 0);
    check("t1_spi_literal", last_spi, 16'hF8A5);
    check("t1_tx_literal", tx_log[$], 8'h06);
    run(8'h52, 8'hF8, 8'h00, 8'h3C, 0, 0, 0);
    check("t2_spi_literal", last_spi, 16'hF800);
    check("t2_tx_hdr_literal", tx_log[tx_log.size() - 2], 8'h72);
    check("t2_tx_dat_literal", tx_log[$], 8'h3C);
    n0 = tx_log.size();
    run(8'h41, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    check("t3_nak_literal", tx_log[$], 8'h15);
    check("t3_nak_count", tx_log.size(), n0 + 1);
    run(8'h57, 8'h01, 8'h02, 8'h00, 0, 0, 0);
    check("t3_next_literal", last_spi, 16'h0102);
    run(8'h57, 8'h5A, 8'hC3, 8'h00, 100, 3, 0);
    check("t4_drop_literal", drop_cnt, 3);
    // reset while waiting for SPI completion
    wait_uart();
    exp_spi.push_back(16'h1122);
    send(8'h57);
    send(8'h11);
    send(8'h22);
    wait_spi_start();
    repeat (3) tick();
    n0 = tx_log.size();
    do_reset();
    spi_complete = 1;
    spi_rx = 8'h99;
    tick();
    spi_complete = 0;
    repeat (30) tick();
    @(negedge clk);
    check("r1_busy", busy, 0);
    check("r1_no_tx", tx_log.size(), n0);
    tick();
    // reset while the data byte is on the UART
    exp_spi.push_back(16'h3300);
    exp_tx.push_back(8'h72);
    exp_tx.push_back(8'h5A);
    n0 = tx_log.size();
    send(8'h52);
    send(8'h33);
    send(8'h00);
    wait_spi_start();
    spi_complete = 1;
    spi_rx = 8'h5A;
    tick();
    spi_complete = 0;
    for (int g = 0; g < 100 && tx_log.size() < n0 + 2; g++) tick();
    check("r2_two_tx", tx_log.size(), n0 + 2);
    repeat (2) tick();
    do_reset();
    wait_uart();
    repeat (10) tick();
    @(negedge clk);
    check("r2_busy", busy, 0);
    check("r2_no_more_tx", tx_log.size(), n0 + 2);
    tick();
`ifdef BLUEJAY_CMD_GAP_TIMEOUT_EN
    exp_tx.push_back(8'h15);
    send(8'h57);
    send(8'hF8);
    wait_idle(17360 + 200);
    check("gap_nak_literal", tx_log[$], 8'h15);
`else
    n0 = tx_log.size();
    exp_spi.push_back(16'hF8A5);
    exp_tx.push_back(8'h06);
    send(8'h57);
    send(8'hF8);
    repeat (300) tick();
    @(negedge clk);
    check("gap_still_busy", busy, 1);
    check("gap_no_tx", tx_log.size(), n0);
    tick();
    spi_phase(8'hA5, 16'hF8A5, 8'h00, 0, 0, 0);
    check("gap_complete_literal", last_spi, 16'hF8A5);
`endif
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(0, 3);
      b = 8'($urandom);
      if (b == 8'h57 || b == 8'h52) b = 8'h41;
      run(sel < 2 ? 8'h57 : sel == 2 ? 8'h52 : b, 8'($urandom), 8'($urandom), 8'($urandom),
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0,
          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    run(8'h57, 8'hAA, 8'h55, 8'h00, 0, 260, 1);
    check("drop_saturate_literal", drop_cnt, 8'hFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
